// File: rtl/bit_serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives start/operands through master; the subtractor answers through slave.
interface bit_serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor step per clock, LSB first.
// The published diff/bout only change on the cycle that completes an operation.
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_serial_subtractor_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             bit_d_s;
    logic             bit_br_s;

    // Full-subtractor cell on the current LSBs, plus next-state selection.
    always_comb begin
        bit_d_s  = ra_q[0] ^ rb_q[0] ^ br_q;
        bit_br_s = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);

        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = {CNT_W{1'b0}};
                    rd_d    = {WIDTH{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                ra_d = {1'b0, ra_q[WIDTH-1:1]};
                rb_d = {1'b0, rb_q[WIDTH-1:1]};
                rd_d = {bit_d_s, rd_q[WIDTH-1:1]};
                br_d = bit_br_s;
                if (cnt_q == CNT_LAST) begin
                    // The last bit is folded straight into the published result.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = {bit_d_s, rd_q[WIDTH-1:1]};
                    bout_d  = bit_br_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= {WIDTH{1'b0}};
            rb_q    <= {WIDTH{1'b0}};
            rd_q    <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Randomised and directed bench for bit_serial_subtractor at WIDTH=8 and WIDTH=16,
// scored against plain unsigned arithmetic.
module tb_bit_serial_subtractor;
    logic clk;
    logic rst;
    int   checks_cnt;
    int   errors_cnt;

    bit_serial_subtractor_if #(.WIDTH(8))  i8 ();
    bit_serial_subtractor_if #(.WIDTH(16)) i16 ();

    bit_serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8.slave));
    bit_serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic bi);
        if (w == 8) begin
            i8.start = s; i8.a = a[7:0]; i8.b = b[7:0]; i8.bin = bi;
        end else begin
            i16.start = s; i16.a = a[15:0]; i16.b = b[15:0]; i16.bin = bi;
        end
    endtask

    function automatic logic done_of(input int w);
        return (w == 8) ? i8.done : i16.done;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 8) ? i8.busy : i16.busy;
    endfunction

    function automatic logic bout_of(input int w);
        return (w == 8) ? i8.bout : i16.bout;
    endfunction

    function automatic logic [31:0] diff_of(input int w);
        return (w == 8) ? {24'd0, i8.diff} : {16'd0, i16.diff};
    endfunction

    // One complete operation: accept, count latency and busy cycles, score result.
    task automatic do_op(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                         input logic bin_in, input bit disturb,
                         output logic [31:0] got_d, output logic got_bo);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bm;
        logic [32:0] ref_r;
        logic        ref_bout;
        int          n;
        int          busy_n;
        mask     = (32'd1 << w) - 32'd1;
        am       = a_in & mask;
        bm       = b_in & mask;
        ref_r    = {1'b0, am} - {1'b0, bm} - {32'd0, bin_in};
        ref_bout = ({1'b0, am} < ({1'b0, bm} + {32'd0, bin_in}));
        @(negedge clk);
        drive(w, 1'b1, am, bm, bin_in);
        @(negedge clk);
        drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
        n = 1;
        busy_n = 0;
        while (!done_of(w) && n < 4 * w) begin
            if (busy_of(w)) busy_n++;
            if (disturb && n == 3) drive(w, 1'b1, 32'hAA, 32'hAA, 1'b0);
            if (disturb && n == 4) drive(w, 1'b0, 32'hAA, 32'hAA, 1'b0);
            @(negedge clk);
            n++;
        end
        check_eq("latency", 64'(n), 64'(w + 1));
        check_eq("busy_cycles", 64'(busy_n), 64'(w));
        check_eq("busy_at_done", 64'(busy_of(w)), 64'd0);
        check_eq("diff", 64'(diff_of(w)), 64'(ref_r[31:0] & mask));
        check_eq("bout", 64'(bout_of(w)), 64'(ref_bout));
        got_d  = diff_of(w);
        got_bo = bout_of(w);
        @(negedge clk);
        check_eq("done_one_cycle", 64'(done_of(w)), 64'd0);
    endtask

    initial begin
        logic [31:0] gd;
        logic        gb;
        logic [8:0]  sum9;
        logic [7:0]  ra8;
        logic [7:0]  rb8;
        int          n;
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(16, 1'b0, 32'd0, 32'd0, 1'b0);
        #12;
        check_eq("rst_busy", 64'(i8.busy), 64'd0);
        check_eq("rst_done", 64'(i8.done), 64'd0);
        check_eq("rst_diff", 64'(i8.diff), 64'd0);
        check_eq("rst_bout", 64'(i8.bout), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the plan.
        do_op(8, 32'd100, 32'd37, 1'b0, 1'b0, gd, gb);
        check_eq("basic_diff", 64'(gd), 64'h3F);
        check_eq("basic_bout", 64'(gb), 64'd0);
        do_op(8, 32'h00, 32'h01, 1'b0, 1'b0, gd, gb);
        check_eq("uf1", 64'({gb, gd[7:0]}), 64'h1FF);
        do_op(8, 32'h80, 32'h80, 1'b1, 1'b0, gd, gb);
        check_eq("uf2", 64'({gb, gd[7:0]}), 64'h1FF);
        do_op(8, 32'hFF, 32'h00, 1'b1, 1'b0, gd, gb);
        check_eq("uf3", 64'({gb, gd[7:0]}), 64'h0FE);
        do_op(8, 32'h55, 32'h0F, 1'b0, 1'b1, gd, gb);
        check_eq("isolate", 64'({gb, gd[7:0]}), 64'h046);

        // Back-to-back with start held high.
        @(negedge clk);
        drive(8, 1'b1, 32'h10, 32'h20, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!i8.done && n < 40);
        check_eq("b2b_lat1", 64'(n), 64'd9);
        check_eq("b2b_res1", 64'({i8.bout, i8.diff}), 64'h1F0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check_eq("b2b_accept_in_done", 64'(i8.busy), 64'd1);
                drive(8, 1'b0, 32'h10, 32'h20, 1'b0);
            end
        end while (!i8.done && n < 40);
        check_eq("b2b_gap", 64'(n), 64'd9);
        check_eq("b2b_res2", 64'({i8.bout, i8.diff}), 64'h1F0);
        @(negedge clk);

        // Reset three cycles into RUN.
        do_op(16, 32'h1234, 32'h0001, 1'b0, 1'b0, gd, gb);
        drive(8, 1'b1, 32'h12, 32'h34, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 32'h12, 32'h34, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(i8.busy), 64'd0);
        check_eq("mid_rst_done", 64'(i8.done), 64'd0);
        check_eq("mid_rst_diff", 64'(i8.diff), 64'd0);
        check_eq("mid_rst_bout", 64'(i8.bout), 64'd0);
        check_eq("mid_rst_diff16", 64'(i16.diff), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("mid_rst_no_done", 64'(i8.done), 64'd0);
        rst = 1'b0;
        do_op(8, 32'hC3, 32'h3C, 1'b1, 1'b0, gd, gb);
        check_eq("after_rst", 64'({gb, gd[7:0]}), 64'h086);

        // Random operations on both widths, plus add-then-subtract round trips.
        for (int i = 0; i < 200; i++) begin
            do_op(8, $urandom, $urandom, 1'($urandom), 1'b0, gd, gb);
            do_op(16, $urandom, $urandom, 1'($urandom), 1'b0, gd, gb);
        end
        for (int i = 0; i < 50; i++) begin
            ra8  = 8'($urandom);
            rb8  = 8'($urandom);
            sum9 = {1'b0, ra8} + {1'b0, rb8};
            do_op(8, {24'd0, sum9[7:0]}, {24'd0, rb8}, 1'b0, 1'b0, gd, gb);
            check_eq("roundtrip_diff", 64'(gd[7:0]), 64'(ra8));
            check_eq("roundtrip_bout", 64'(gb), 64'(sum9[8]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
